// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared I2S receiver types, channel constant and counter sizing helper
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  localparam logic I2S_LEFT = 1'b0;

  // One extra bit so the counter can hold MAX_SLOT_BITS itself when saturated.
  function automatic int bit_cnt_width(input int max_slot_bits);
    return $clog2(max_slot_bits) + 1;
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - two-flop synchronizer with previous-value flop and rise detect
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~prev;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver, oversampled in clk, emits left/right PCM pairs
// Peak meters are built only when I2S_RX_PEAK_EN is defined.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int MAX_SLOT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    i2s_lrck,
  input  logic                    i2s_bck,
  input  logic                    i2s_data,
  input  logic                    err_clr,
`ifdef I2S_RX_PEAK_EN
  input  logic                    peak_clr,
  output logic [SAMPLE_WIDTH-1:0] peak_left,
  output logic [SAMPLE_WIDTH-1:0] peak_right,
`endif
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    locked,
  output logic                    short_err
);

  localparam int CW = bit_cnt_width(MAX_SLOT_BITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_SLOT_BITS);
  localparam logic [CW-1:0] CNT_SHORT = CW'(SAMPLE_WIDTH - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MSB_ONE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic lrck_s;
  logic bck_rise;
  logic data_s;
  logic bck_s_unused;
  logic lrck_rise_unused;
  logic data_rise_unused;

  i2s_sync_edge u_sync_bck (
    .clk  (clk),
    .rst  (rst),
    .din  (i2s_bck),
    .sync (bck_s_unused),
    .rise (bck_rise)
  );

  i2s_sync_edge u_sync_lrck (
    .clk  (clk),
    .rst  (rst),
    .din  (i2s_lrck),
    .sync (lrck_s),
    .rise (lrck_rise_unused)
  );

  i2s_sync_edge u_sync_data (
    .clk  (clk),
    .rst  (rst),
    .din  (i2s_data),
    .sync (data_s),
    .rise (data_rise_unused)
  );

  i2s_state_t              state;
  logic                    lr_prev;
  logic                    left_ok;
  logic [CW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic [SAMPLE_WIDTH-1:0] left_hold;

  logic                    change;
  logic                    short_slot;
  logic [SAMPLE_WIDTH-1:0] bit_mask;
  logic [SAMPLE_WIDTH-1:0] word;

  // Positions at or beyond SAMPLE_WIDTH shift the mask out entirely, so late bits drop.
  assign bit_mask   = MSB_ONE >> bit_cnt;
  assign word       = data_s ? (shreg | bit_mask) : shreg;
  assign change     = bck_rise && (lrck_s != lr_prev);
  assign short_slot = bit_cnt < CNT_SHORT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HUNT;
      lr_prev      <= 1'b0;
      left_ok      <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (err_clr) begin
        short_err <= 1'b0;
      end

      if (bck_rise) begin
        lr_prev <= lrck_s;
        if (change) begin
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          shreg <= word;
          if (bit_cnt != CNT_MAX) begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end

      // A change edge carries the final bit of the slot that is closing.
      if (!enable) begin
        state   <= HUNT;
        locked  <= 1'b0;
        left_ok <= 1'b0;
      end else if (change) begin
        case (state)
          HUNT: begin
            state   <= (lrck_s == I2S_LEFT) ? LEFT : RIGHT;
            locked  <= 1'b1;
            left_ok <= 1'b0;
          end
          LEFT: begin
            left_hold <= word;
            left_ok   <= 1'b1;
            state     <= RIGHT;
            if (short_slot) begin
              short_err <= 1'b1;
            end
          end
          RIGHT: begin
            if (left_ok) begin
              left_sample  <= left_hold;
              right_sample <= word;
              sample_valid <= 1'b1;
            end
            state <= LEFT;
            if (short_slot) begin
              short_err <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef I2S_RX_PEAK_EN
  function automatic logic [SAMPLE_WIDTH-1:0] magnitude(input logic [SAMPLE_WIDTH-1:0] v);
    return v[SAMPLE_WIDTH-1] ? ((~v) + SAMPLE_WIDTH'(1)) : v;
  endfunction

  logic [SAMPLE_WIDTH-1:0] mag_left;
  logic [SAMPLE_WIDTH-1:0] mag_right;

  assign mag_left  = magnitude(left_sample);
  assign mag_right = magnitude(right_sample);

  // Runs while sample_valid is high, when the sample registers already hold the new pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (sample_valid) begin
      peak_left  <= (peak_clr || (mag_left  > peak_left))  ? mag_left  : peak_left;
      peak_right <= (peak_clr || (mag_right > peak_right)) ? mag_right : peak_right;
    end else if (peak_clr) begin
      peak_left  <= '0;
      peak_right <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx with a slot-level reference model
module tb_i2s_rx;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic lrck = 1'b0;
  logic bck = 1'b0;
  logic data = 1'b0;
  logic err_clr = 1'b0;
  logic [W-1:0] left_sample;
  logic [W-1:0] right_sample;
  logic sample_valid;
  logic locked;
  logic short_err;
`ifdef I2S_RX_PEAK_EN
  logic peak_clr = 1'b0;
  logic [W-1:0] peak_left;
  logic [W-1:0] peak_right;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_WIDTH(W), .MAX_SLOT_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i2s_lrck     (lrck),
    .i2s_bck      (bck),
    .i2s_data     (data),
    .err_clr      (err_clr),
`ifdef I2S_RX_PEAK_EN
    .peak_clr     (peak_clr),
    .peak_left    (peak_left),
    .peak_right   (peak_right),
`endif
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .short_err    (short_err)
  );

  // Serial stream: one entry per bck rise, plus the slot it belongs to.
  bit dq[$];
  bit lq[$];
  int bs[$];
  int bp[$];
  int s_lr[$];
  int s_len[$];
  logic [W-1:0] s_word[$];
  logic [W-1:0] exp_l[$];
  logic [W-1:0] exp_r[$];
  logic [W-1:0] got_l[$];
  logic [W-1:0] got_r[$];

  always @(negedge clk) begin
    if (sample_valid) begin
      got_l.push_back(left_sample);
      got_r.push_back(right_sample);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_slot(input int lr, input int len, input logic [W-1:0] w);
    logic [W-1:0] ew;
    ew = w;
    if (len < W) ew = (w >> (W - len)) << (W - len);
    for (int p = 0; p < len; p++) begin
      dq.push_back(p < W ? w[W-1-p] : 1'($urandom));
      lq.push_back(lr[0]);
      bs.push_back(s_lr.size());
      bp.push_back(p);
    end
    s_lr.push_back(lr);
    s_len.push_back(len);
    s_word.push_back(ew);
  endtask

  // Slot 0 is never trusted and the last slot never closes; a disturbance inside
  // slot 'drop' loses that slot and the one after it.
  task automatic build_expect(input int drop);
    exp_l.delete();
    exp_r.delete();
    for (int i = 1; i + 1 <= s_lr.size() - 2; i++) begin
      if (s_lr[i] == 0 && s_lr[i+1] == 1 && (drop < 0 || i + 1 < drop || i > drop + 1)) begin
        exp_l.push_back(s_word[i]);
        exp_r.push_back(s_word[i+1]);
      end
    end
  endtask

  function automatic logic exp_short();
    logic s;
    s = 1'b0;
    for (int i = 1; i <= s_lr.size() - 2; i++) if (s_len[i] < W) s = 1'b1;
    return s;
  endfunction

  task automatic play(input int ev_slot, input int ev_pos, input int ev_kind);
    for (int i = 0; i < dq.size(); i++) begin
      if (ev_kind != 0 && bs[i] == ev_slot && bp[i] == ev_pos) begin
        if (ev_kind == 1) begin
          enable = 1'b0;
          tick(2);
          check("locked_en_low", locked, 0);
          tick(8);
          enable = 1'b1;
        end else begin
          rst = 1'b0;
          #1;
          check("rst_mid_left", left_sample, 0);
          check("rst_mid_right", right_sample, 0);
          check("rst_mid_locked", locked, 0);
          check("rst_mid_valid", sample_valid, 0);
          tick(3);
          rst = 1'b1;
        end
      end
      lrck = lq[(i + 1 < lq.size()) ? i + 1 : i];
      data = dq[i];
      tick(4);
      bck = 1'b1;
      tick(4);
      bck = 1'b0;
    end
  endtask

  task automatic finish_run(input string tag);
    tick(20);
    check({tag, "_pulses"}, got_l.size(), exp_l.size());
    for (int k = 0; k < exp_l.size() && k < got_l.size(); k++) begin
      check({tag, "_left"}, got_l[k], exp_l[k]);
      check({tag, "_right"}, got_r[k], exp_r[k]);
    end
    dq.delete(); lq.delete(); bs.delete(); bp.delete();
    s_lr.delete(); s_len.delete(); s_word.delete();
    got_l.delete(); got_r.delete();
  endtask

  task automatic rehunt();
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    logic es;
    int len;
    tick(3);
    check("reset_left", left_sample, 0);
    check("reset_right", right_sample, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_locked", locked, 0);
    check("reset_short", short_err, 0);
    rst = 1'b1;
    enable = 1'b1;
    tick(2);

    // basic 32-bit frames
    add_slot(0, 32, 16'($urandom));
    add_slot(1, 32, 16'($urandom));
    for (int f = 0; f < 3; f++) begin
      add_slot(0, 32, 16'h1234);
      add_slot(1, 32, 16'hABCD);
    end
    add_slot(0, 2, 16'($urandom));
    build_expect(-1);
    es = exp_short();
    play(-1, 0, 0);
    finish_run("basic");
    check("basic_left_out", left_sample, 16'h1234);
    check("basic_right_out", right_sample, 16'hABCD);
    check("basic_short", short_err, es);
    check("basic_locked", locked, 1);

    // random words, slot lengths 16..40 (first frame at exactly 16)
    rehunt();
    add_slot(0, 32, 16'($urandom));
    add_slot(1, 32, 16'($urandom));
    for (int f = 0; f < 5; f++) begin
      len = (f == 0) ? 16 : int'($urandom_range(16, 40));
      add_slot(0, len, 16'($urandom));
      add_slot(1, len, 16'($urandom));
    end
    add_slot(0, 2, 16'($urandom));
    build_expect(-1);
    es = exp_short();
    play(-1, 0, 0);
    finish_run("random");
    check("random_short", short_err, es);

    // stream begins mid-right-slot
    rehunt();
    add_slot(1, 10, 16'($urandom));
    add_slot(0, 32, 16'($urandom));
    add_slot(1, 32, 16'($urandom));
    add_slot(0, 2, 16'($urandom));
    build_expect(-1);
    play(-1, 0, 0);
    finish_run("partial");
    check("partial_locked", locked, 1);

    // 8-bit slots
    rehunt();
    add_slot(0, 8, 16'($urandom));
    add_slot(1, 8, 16'($urandom));
    add_slot(0, 8, 16'hA500);
    add_slot(1, 8, 16'h3C00);
    add_slot(0, 2, 16'($urandom));
    build_expect(-1);
    play(-1, 0, 0);
    finish_run("short");
    check("short_left_out", left_sample, 16'hA500);
    check("short_right_out", right_sample, 16'h3C00);
    check("short_flag", short_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("short_cleared", short_err, 0);

    // enable drop and async reset, each at bit 5 of left slot 4
    for (int kind = 1; kind <= 2; kind++) begin
      rehunt();
      for (int s = 0; s < 8; s++) add_slot(s % 2, 32, 16'($urandom));
      add_slot(0, 2, 16'($urandom));
      build_expect(4);
      play(4, 5, kind);
      finish_run(kind == 1 ? "enable" : "reset");
      check(kind == 1 ? "enable_relock" : "reset_relock", locked, 1);
    end

`ifdef I2S_RX_PEAK_EN
    begin
      int pl;
      int pr;
      int v;
      rehunt();
      peak_clr = 1'b1;
      tick(1);
      peak_clr = 1'b0;
      add_slot(0, 32, 16'($urandom));
      add_slot(1, 32, 16'($urandom));
      add_slot(0, 32, 16'h8000);
      add_slot(1, 32, 16'hFFFF);
      add_slot(0, 32, 16'h0100);
      add_slot(1, 32, 16'h7FFF);
      add_slot(0, 2, 16'($urandom));
      build_expect(-1);
      pl = 0;
      pr = 0;
      for (int k = 0; k < exp_l.size(); k++) begin
        v = int'($signed(exp_l[k]));
        if (v < 0) v = -v;
        if (v > pl) pl = v;
        v = int'($signed(exp_r[k]));
        if (v < 0) v = -v;
        if (v > pr) pr = v;
      end
      play(-1, 0, 0);
      finish_run("peak");
      check("peak_left", peak_left, pl);
      check("peak_right", peak_right, pr);
      peak_clr = 1'b1;
      tick(1);
      peak_clr = 1'b0;
      check("peak_left_clr", peak_left, 0);
      check("peak_right_clr", peak_right, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
